rotation_finder: RTL

- Multi-cycle companion to the ALU circular shifter, working in the inverse direction.
- Given a reference byte and a target byte, it searches for the rotation that maps the reference onto the target.
- It reports the minimal shift amount and direction in the shifter's encoding (ShiftDir 1 = right, 0 = left).
- Used by the rotate-compare instruction path and by the self-test sequencer to check shifter results.

---
 rtl/rotation_finder.sv | 83 ++++++++
 1 files changed

// File: rtl/rotation_finder.sv
// rotation_finder: finds the minimal rotation mapping Ref onto Target in the shifter's encoding.
// Defining ROT_BIDIR_EN searches both directions in parallel, which shortens the search.
module rotation_finder #(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] Ref,
   input  logic [WIDTH-1:0] Target,
   output logic             Busy,
   output logic             Valid,
   output logic             Found,
   output logic [AMT_W-1:0] ShiftAmt,
   output logic             ShiftDir
);
   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
   state_t state, nextState;
   logic [WIDTH-1:0] rotR, tgt;
   logic [AMT_W-1:0] cnt;
   logic accept, hitR, hitL, lastCnt;
   assign hitR = rotR == tgt;
`ifdef ROT_BIDIR_EN
   logic [WIDTH-1:0] rotL;
   assign hitL = rotL == tgt;
   assign lastCnt = cnt == AMT_W'(WIDTH / 2);
`else
   assign hitL = 1'b0;
   assign lastCnt = cnt == AMT_W'(WIDTH - 1);
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nextState;
   always_comb begin
      nextState = state;
      Busy = state == SEARCH;
      Valid = state == DONE;
      accept = Start && !Busy;
      if (accept) nextState = SEARCH;
      else if (state == SEARCH) nextState = (hitR || hitL || lastCnt) ? DONE : SEARCH;
      else if (state == DONE) nextState = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rotR <= '0;
         tgt <= '0;
         cnt <= '0;
         Found <= 1'b0;
         ShiftAmt <= '0;
         ShiftDir <= 1'b1;
`ifdef ROT_BIDIR_EN
         rotL <= '0;
`endif
      end else if (accept) begin
         rotR <= Ref;
         tgt <= Target;
         cnt <= '0;
         Found <= 1'b0;
         ShiftAmt <= '0;
         ShiftDir <= 1'b1;
`ifdef ROT_BIDIR_EN
         rotL <= Ref;
`endif
      end else if (state == SEARCH) begin
         // a right match past the halfway point is shorter as a left rotation
         if (hitR) begin
            Found <= 1'b1;
            ShiftAmt <= (cnt > AMT_W'(WIDTH / 2)) ? AMT_W'(WIDTH) - cnt : cnt;
            ShiftDir <= cnt <= AMT_W'(WIDTH / 2);
         end else if (hitL) begin
            Found <= 1'b1;
            ShiftAmt <= cnt;
            ShiftDir <= 1'b0;
         end else if (!lastCnt) begin
            rotR <= {rotR[0], rotR[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
`ifdef ROT_BIDIR_EN
            rotL <= {rotL[WIDTH-2:0], rotL[WIDTH-1]};
`endif
         end
      end
endmodule
